// File: rtl/neuron_pkg.sv
// Shared types and helpers for the multi-lane MAC neuron: activation and FSM
// encodings, drain depth, and a width-generic saturating adder.
package neuron_pkg;

  typedef enum logic [1:0] {
    ACT_RELU    = 2'd0,
    ACT_LINEAR  = 2'd1,
    ACT_SIGMOID = 2'd2
  } act_mode_e;

  typedef enum logic [2:0] {
    ST_ACCUM,
    ST_DRAIN,
    ST_BIAS,
    ST_ACT,
    ST_OUT
  } neuron_state_e;

  localparam int DRAIN_CYCLES = 3;

  // Operands are sign-extended into 64 bits; the result is clamped to the
  // signed range of a w-bit word (w <= 64) and returned sign-extended.
  function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                 input logic signed [63:0] b,
                                                 input int unsigned w);
    logic signed [64:0] s, hi, lo;
    s  = 65'(a) + 65'(b);
    hi = (65'sd1 <<< (w - 1)) - 65'sd1;
    lo = -hi - 65'sd1;
    if (s > hi)      return 64'(hi);
    else if (s < lo) return 64'(lo);
    else             return 64'(s);
  endfunction

  function automatic logic sat_hit(input logic signed [63:0] a,
                                   input logic signed [63:0] b,
                                   input int unsigned w);
    logic signed [64:0] s, hi, lo;
    s  = 65'(a) + 65'(b);
    hi = (65'sd1 <<< (w - 1)) - 65'sd1;
    lo = -hi - 65'sd1;
    return (s > hi) || (s < lo);
  endfunction

endpackage

// File: rtl/neuron_lane_wmem.sv
// Per-lane weight RAM: one write port, one registered read port.
// A same-cycle write and read of one address returns the old word.
module neuron_lane_wmem
  import neuron_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 196,
  parameter int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/neuron_mac_lanes.sv
// LANES-wide signed MAC neuron with loadable weights/bias and selectable
// activation. Define NEURON_OVF_STICKY_EN to build the sticky saturation flag.
module neuron_mac_lanes
  import neuron_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int NUM_WEIGHT = 784,
  parameter int LANES      = 4,
  parameter int INT_W      = 1,
  parameter int SIG_W      = 10,
  parameter int LAYER_NO   = 1,
  parameter int NEURON_NO  = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [LANES*DATA_W-1:0] in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    weight_valid,
  input  logic [31:0]             weight_value,
  input  logic                    bias_valid,
  input  logic [31:0]             bias_value,
  input  logic [31:0]             config_layer_num,
  input  logic [31:0]             config_neuron_num,
  input  logic [1:0]              act_mode,
  output logic [DATA_W-1:0]       out,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    ovf
);

  localparam int BEATS  = NUM_WEIGHT / LANES;
  localparam int AW     = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int LW     = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int ACC_W  = 2 * DATA_W;
  localparam int TREE_W = ACC_W + $clog2(LANES);
  localparam int DCW    = $clog2(DRAIN_CYCLES + 1);

  if (NUM_WEIGHT % LANES != 0) begin : g_bad_cfg
    $error("NUM_WEIGHT must be a multiple of LANES");
  end

  neuron_state_e state, state_n;

  logic                    cfg_hit, accept, last_beat, out_hs;
  logic [AW-1:0]           beat_cnt, waddr, raddr0;
  logic [LW-1:0]           wlane;
  logic [DCW-1:0]          drain_cnt;
  logic [DATA_W-1:0]       bias_reg;
  logic                    v0, v1, v2;
  logic [LANES*DATA_W-1:0] d0, d1;
  logic [DATA_W-1:0]       rdata [LANES];
  logic signed [ACC_W-1:0] prod [LANES];
  logic signed [TREE_W-1:0] tree;
  logic signed [ACC_W-1:0] acc, tree_sat, acc_mac, acc_bias, bias_ext;
  logic [INT_W:0]          top_bits;
  logic                    slice_ok, slice_used;
  logic [DATA_W-1:0]       slice_sat, act_val;
  logic                    unused_bits;

  assign unused_bits = ^{weight_value[31:DATA_W], bias_value[31:DATA_W]};

  assign cfg_hit   = (config_layer_num == 32'(LAYER_NO)) &&
                     (config_neuron_num == 32'(NEURON_NO));
  assign in_ready  = (state == ST_ACCUM) && rst;
  assign accept    = in_valid && in_ready;
  assign last_beat = (beat_cnt == AW'(BEATS - 1));
  assign out_hs    = (state == ST_OUT) && out_ready;

  always_ff @(posedge clk) begin
    if (!rst) state <= ST_ACCUM;
    else      state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      ST_ACCUM: if (accept && last_beat) state_n = ST_DRAIN;
      ST_DRAIN: if (drain_cnt == DCW'(DRAIN_CYCLES - 1)) state_n = ST_BIAS;
      ST_BIAS:  state_n = ST_ACT;
      ST_ACT:   state_n = ST_OUT;
      ST_OUT:   if (out_ready) state_n = ST_ACCUM;
      default:  state_n = ST_ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      beat_cnt  <= '0;
      drain_cnt <= '0;
    end else begin
      if (out_hs)                     beat_cnt <= '0;
      else if (accept && !last_beat)  beat_cnt <= beat_cnt + AW'(1);
      drain_cnt <= (state == ST_DRAIN) ? drain_cnt + DCW'(1) : '0;
    end
  end

  // Weight k lands in lane k%LANES at address k/LANES.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wlane    <= '0;
      waddr    <= '0;
      bias_reg <= '0;
    end else begin
      if (weight_valid && cfg_hit) begin
        if (wlane == LW'(LANES - 1)) begin
          wlane <= '0;
          waddr <= (waddr == AW'(BEATS - 1)) ? '0 : waddr + AW'(1);
        end else begin
          wlane <= wlane + LW'(1);
        end
      end
      if (bias_valid && cfg_hit) bias_reg <= bias_value[DATA_W-1:0];
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    neuron_lane_wmem #(
      .DATA_W(DATA_W),
      .DEPTH (BEATS),
      .AW    (AW)
    ) u_wmem (
      .clk  (clk),
      .we   (weight_valid && cfg_hit && (wlane == LW'(i))),
      .waddr(waddr),
      .wdata(weight_value[DATA_W-1:0]),
      .raddr(raddr0),
      .rdata(rdata[i])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      v0 <= 1'b0;
      v1 <= 1'b0;
      v2 <= 1'b0;
    end else begin
      v0 <= accept;
      v1 <= v0;
      v2 <= v1;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      d0     <= in_data;
      raddr0 <= beat_cnt;
    end
    d1 <= d0;
    if (v1) begin
      for (int unsigned i = 0; i < LANES; i++)
        prod[i] <= $signed(d1[i*DATA_W +: DATA_W]) * $signed(rdata[i]);
    end
  end

  always_comb begin
    tree = '0;
    for (int unsigned i = 0; i < LANES; i++) tree = tree + TREE_W'(prod[i]);
  end

  // The tree sum is clamped on its own before it meets the accumulator.
  assign tree_sat = ACC_W'(sat_add(64'(tree), 64'sd0, ACC_W));
  assign acc_mac  = ACC_W'(sat_add(64'(tree_sat), 64'(acc), ACC_W));
  assign bias_ext = {bias_reg, {DATA_W{1'b0}}};
  assign acc_bias = ACC_W'(sat_add(64'(bias_ext), 64'(acc), ACC_W));

  always_ff @(posedge clk) begin
    if (!rst)                  acc <= '0;
    else if (out_hs)           acc <= '0;
    else if (state == ST_BIAS) acc <= acc_bias;
    else if (v2)               acc <= acc_mac;
  end

  assign top_bits  = acc[ACC_W-1 -: INT_W+1];
  assign slice_ok  = (top_bits == '0) || (top_bits == '1);
  assign slice_sat = slice_ok ? acc[ACC_W-1-INT_W -: DATA_W] :
                     acc[ACC_W-1] ? {1'b1, {(DATA_W-1){1'b0}}} :
                                    {1'b0, {(DATA_W-1){1'b1}}};

  always_comb begin
    act_val    = slice_sat;
    slice_used = 1'b1;
    case (act_mode_e'(act_mode))
      ACT_RELU: begin
        act_val    = acc[ACC_W-1] ? '0 : slice_sat;
        slice_used = !acc[ACC_W-1];
      end
      ACT_SIGMOID: begin
        act_val    = DATA_W'(acc[ACC_W-1 -: SIG_W]);
        slice_used = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      out       <= '0;
      out_valid <= 1'b0;
    end else if (state == ST_ACT) begin
      out       <= act_val;
      out_valid <= 1'b1;
    end else if (out_hs) begin
      out_valid <= 1'b0;
    end
  end

`ifdef NEURON_OVF_STICKY_EN
  logic mac_sat, bias_sat, run_ovf, ovf_q;

  assign mac_sat  = sat_hit(64'(tree), 64'sd0, ACC_W) ||
                    sat_hit(64'(tree_sat), 64'(acc), ACC_W);
  assign bias_sat = sat_hit(64'(bias_ext), 64'(acc), ACC_W);

  always_ff @(posedge clk) begin
    if (!rst) begin
      run_ovf <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (out_hs) begin
      run_ovf <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      if ((v2 && mac_sat) || (state == ST_BIAS && bias_sat)) run_ovf <= 1'b1;
      if (state == ST_ACT) ovf_q <= run_ovf || (slice_used && !slice_ok);
    end
  end

  assign ovf = ovf_q;
`else
  logic unused_sat;
  assign unused_sat = slice_used ^ slice_ok;
  assign ovf = 1'b0;
`endif

endmodule
